offchip_port_arbiter: RTL and testbench

- Shares one off-chip memory port among N_PORTS cache-line marshallers.
- Each upstream port uses the marshaller's memory-side protocol: request held with stable ADDR/D until a one-cycle RDY pulse.
- Round-robin arbitration, one transaction in flight at a time. Sits between the per-cache marshallers and the off-chip memory controller.

---
 rtl/offchip_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_offchip_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offchip_port_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port among N_PORTS
// cache-line marshallers; one transaction in flight, all outputs registered.
module offchip_port_arbiter #(
    parameter int N_PORTS = 4,
    parameter int W_A     = 32,
    parameter int W_D     = 512,
    parameter int W_ID    = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_PORTS*W_A-1:0] REQ_ADDR,
    input  logic [N_PORTS*W_D-1:0] REQ_D,
    input  logic [N_PORTS-1:0]     REQ_WE,
    input  logic [N_PORTS-1:0]     REQ_RE,
    output logic [W_D-1:0]         REQ_Q,
    output logic [N_PORTS-1:0]     REQ_RDY,
    output logic [W_A-1:0]         MEM_ADDR,
    output logic [W_D-1:0]         MEM_D,
    output logic                   MEM_WE,
    output logic                   MEM_RE,
    input  logic [W_D-1:0]         MEM_Q,
    input  logic                   MEM_RDY,
    output logic [W_ID-1:0]        GRANT_ID,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t              state, state_nx;
    logic [W_ID-1:0]     ptr, ptr_nx;
    logic [W_ID-1:0]     gid, gid_nx;
    logic [N_PORTS-1:0]  rdy, rdy_nx;
    logic                we, we_nx;
    logic                re, re_nx;
    logic                busy, busy_nx;
    logic [W_A-1:0]      addr, addr_nx;
    logic [W_D-1:0]      d, d_nx;
    logic [W_D-1:0]      q, q_nx;

    logic [N_PORTS-1:0]  req;
    logic                hit;
    logic [W_ID-1:0]     win;

    assign req = REQ_WE | REQ_RE;

    // Scan from the far end so the port nearest the pointer wins last.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (req[W_ID'(j)]) begin
                hit = 1'b1;
                win = W_ID'(j);
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gid_nx   = gid;
        rdy_nx   = '0;
        we_nx    = we;
        re_nx    = re;
        addr_nx  = addr;
        d_nx     = d;
        q_nx     = q;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    gid_nx   = win;
                    addr_nx  = REQ_ADDR[int'(win)*W_A +: W_A];
                    d_nx     = REQ_D[int'(win)*W_D +: W_D];
                    we_nx    = REQ_WE[win];
                    re_nx    = REQ_RE[win] & ~REQ_WE[win];
                    ptr_nx   = (int'(win) == N_PORTS - 1) ? '0 : win + 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (MEM_RDY) begin
                    we_nx       = 1'b0;
                    re_nx       = 1'b0;
                    rdy_nx[gid] = 1'b1;
                    if (re) q_nx = MEM_Q;
                    state_nx    = RESP;
                end
            end
            RESP: begin
                // Winner's request is still high here, so no arbitration.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= '0;
            gid   <= '0;
            rdy   <= '0;
            we    <= 1'b0;
            re    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gid   <= gid_nx;
            rdy   <= rdy_nx;
            we    <= we_nx;
            re    <= re_nx;
            busy  <= busy_nx;
        end
    end

    always_ff @(posedge CLK) begin
        addr <= addr_nx;
        d    <= d_nx;
        q    <= q_nx;
    end

    assign REQ_Q    = q;
    assign REQ_RDY  = rdy;
    assign MEM_ADDR = addr;
    assign MEM_D    = d;
    assign MEM_WE   = we;
    assign MEM_RE   = re;
    assign GRANT_ID = gid;
    assign BUSY     = busy;

endmodule

// File: tb/tb_offchip_port_arbiter.sv
// Bench for offchip_port_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_offchip_port_arbiter;

    localparam int N  = 4;
    localparam int WA = 32;
    localparam int WD = 512;
    localparam int WI = 2;

    logic            CLK;
    logic            RST;
    logic [N*WA-1:0] REQ_ADDR;
    logic [N*WD-1:0] REQ_D;
    logic [N-1:0]    REQ_WE;
    logic [N-1:0]    REQ_RE;
    logic [WD-1:0]   REQ_Q;
    logic [N-1:0]    REQ_RDY;
    logic [WA-1:0]   MEM_ADDR;
    logic [WD-1:0]   MEM_D;
    logic            MEM_WE;
    logic            MEM_RE;
    logic [WD-1:0]   MEM_Q;
    logic            MEM_RDY;
    logic [WI-1:0]   GRANT_ID;
    logic            BUSY;

    offchip_port_arbiter #(
        .N_PORTS(N), .W_A(WA), .W_D(WD), .W_ID(WI)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_ADDR(REQ_ADDR), .REQ_D(REQ_D),
        .REQ_WE(REQ_WE), .REQ_RE(REQ_RE),
        .REQ_Q(REQ_Q), .REQ_RDY(REQ_RDY),
        .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D),
        .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
        .MEM_Q(MEM_Q), .MEM_RDY(MEM_RDY),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;

    // Reference model: one in-flight transaction and a response pulse.
    bit            m_txn;
    bit            m_resp;
    int            m_ptr;
    int            m_port;
    bit            m_isr;
    bit            q_known;
    logic [N-1:0]  e_rdy;
    logic          e_we, e_re, e_busy;
    logic [WI-1:0] e_gid;
    logic [WA-1:0] e_addr;
    logic [WD-1:0] e_d, e_q;
    int            waitg[N];
    int            glog[$];

    int            rem[N];
    bit            refill;
    int            mem_mode;
    int            rdy_cnt[N];

    task automatic chk(string tag, logic [WD-1:0] obs, logic [WD-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WD-1:0] rnd_d();
        logic [WD-1:0] r;
        for (int k = 0; k < WD / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_req(int i, logic we, logic re,
                           logic [WA-1:0] a, logic [WD-1:0] dd);
        REQ_WE[i] = we;
        REQ_RE[i] = re;
        REQ_ADDR[i*WA +: WA] = a;
        REQ_D[i*WD +: WD] = dd;
    endtask

    task automatic clr_req(int i);
        REQ_WE[i] = 1'b0;
        REQ_RE[i] = 1'b0;
    endtask

    task automatic rand_req(int i);
        int kind;
        kind = int'($urandom % 3);
        set_req(i, kind != 1, kind != 0, $urandom, rnd_d());
    endtask

    task automatic step();
        logic            rst_s, mr_s;
        logic [N-1:0]    we_s, re_s;
        logic [N*WA-1:0] a_s;
        logic [N*WD-1:0] d_s;
        logic [WD-1:0]   mq_s;
        rst_s = RST; mr_s = MEM_RDY; we_s = REQ_WE; re_s = REQ_RE;
        a_s = REQ_ADDR; d_s = REQ_D; mq_s = MEM_Q;
        @(posedge CLK);
        #1;
        if (rst_s) begin
            m_txn = 0; m_resp = 0; m_ptr = 0; q_known = 0;
            e_rdy = '0; e_we = 0; e_re = 0; e_gid = '0; e_busy = 0;
            for (int p = 0; p < N; p++) waitg[p] = 0;
        end else if (m_resp) begin
            m_resp = 0; e_rdy = '0; e_busy = 0;
        end else if (m_txn) begin
            if (mr_s) begin
                m_txn = 0; m_resp = 1; e_we = 0; e_re = 0;
                e_rdy = N'(1) << m_port;
                if (m_isr) begin e_q = mq_s; q_known = 1; end
            end
        end else begin
            int w, maxw;
            w = -1;
            maxw = 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (w < 0 && (we_s[p] | re_s[p])) w = p;
            end
            if (w >= 0) begin
                for (int p = 0; p < N; p++) begin
                    if (p == w || !(we_s[p] | re_s[p])) waitg[p] = 0;
                    else waitg[p]++;
                    if (waitg[p] > maxw) maxw = waitg[p];
                end
                chk("fairness", WD'(maxw < N), WD'(1));
                m_port = w;
                m_isr  = re_s[w] & ~we_s[w];
                e_we   = we_s[w];
                e_re   = m_isr;
                e_gid  = WI'(w);
                e_addr = a_s[w*WA +: WA];
                e_d    = d_s[w*WD +: WD];
                m_ptr  = (w + 1) % N;
                m_txn  = 1; e_busy = 1;
                glog.push_back(w);
            end
        end
        chk("req_rdy", WD'(REQ_RDY), WD'(e_rdy));
        chk("rdy_onehot", WD'($countones(REQ_RDY) <= 1), WD'(1));
        chk("mem_we", WD'(MEM_WE), WD'(e_we));
        chk("mem_re", WD'(MEM_RE), WD'(e_re));
        chk("grant_id", WD'(GRANT_ID), WD'(e_gid));
        chk("busy", WD'(BUSY), WD'(e_busy));
        if (e_we | e_re) begin
            chk("mem_addr", WD'(MEM_ADDR), WD'(e_addr));
            chk("mem_d", MEM_D, e_d);
        end
        if (e_rdy != '0 && q_known) chk("req_q", REQ_Q, e_q);
    endtask

    task automatic agent();
        for (int i = 0; i < N; i++) begin
            if (REQ_RDY[i]) begin
                rem[i]--;
                if (rem[i] > 0) rand_req(i);
                else clr_req(i);
            end
        end
        if (refill) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && !REQ_WE[i] && !REQ_RE[i]
                    && $urandom % 4 == 0) begin
                    rem[i] = 1 + int'($urandom % 3);
                    rand_req(i);
                end
            end
        end
        if (mem_mode != 0) begin
            MEM_Q   = rnd_d();
            MEM_RDY = (mem_mode == 1) ? 1'b1 : ($urandom % 3 == 0);
        end
    endtask

    task automatic cyc();
        step();
        agent();
    endtask

    initial begin
        int exp2[4];
        int tot;
        logic [WD-1:0] qv;
        exp2 = '{0, 2, 3, 0};
        RST = 1; REQ_WE = '0; REQ_RE = '0; REQ_ADDR = '0; REQ_D = '0;
        MEM_Q = '0; MEM_RDY = 0; refill = 0; mem_mode = 0;
        for (int i = 0; i < N; i++) begin rem[i] = 0; rdy_cnt[i] = 0; end

        // Reset, then a read from port 1 with three wait cycles
        step(); step();
        chk("rst_busy", WD'(BUSY), WD'(0));
        chk("rst_gid", WD'(GRANT_ID), WD'(0));
        RST = 0;
        set_req(1, 0, 1, 32'h1000, rnd_d());
        step();
        chk("t1_re", WD'(MEM_RE), WD'(1));
        chk("t1_addr", WD'(MEM_ADDR), WD'(32'h1000));
        step(); step(); step();
        chk("t1_wait", WD'(REQ_RDY), WD'(0));
        MEM_RDY = 1; MEM_Q = {64{8'hA5}};
        step();
        chk("t1_rdy", WD'(REQ_RDY), WD'(4'b0010));
        chk("t1_q", REQ_Q, {64{8'hA5}});
        MEM_RDY = 0; clr_req(1);
        step();
        chk("t1_busy_fall", WD'(BUSY), WD'(0));

        // Grant order from pointer 0 with port 0 re-requesting
        RST = 1; step(); RST = 0;
        glog.delete();
        rem[0] = 2; rem[2] = 1; rem[3] = 1;
        rand_req(0); rand_req(2); rand_req(3);
        mem_mode = 1; MEM_RDY = 1;
        for (int c = 0; c < 40 && glog.size() < 4; c++) cyc();
        chk("t2_ngrants", WD'(glog.size() >= 4), WD'(1));
        for (int k = 0; k < 4; k++)
            chk("t2_order", WD'(glog.size() > k ? glog[k] : -1), WD'(exp2[k]));
        for (int c = 0; c < 6; c++) cyc();
        mem_mode = 0; MEM_RDY = 0; step();

        // Spurious MEM_RDY while idle
        MEM_RDY = 1; step(); step();
        chk("t6_idle_rdy", WD'(REQ_RDY), WD'(0));
        chk("t6_idle_busy", WD'(BUSY), WD'(0));

        // Eviction write then read from port 2 while port 3 waits
        MEM_RDY = 0;
        set_req(2, 1, 0, 32'h2000, {64{8'h55}});
        step();
        chk("t3_we", WD'(MEM_WE), WD'(1));
        chk("t3_d", MEM_D, {64{8'h55}});
        chk("t3_gid", WD'(GRANT_ID), WD'(2));
        MEM_RDY = 1;
        step();
        chk("t3_rdy2", WD'(REQ_RDY), WD'(4'b0100));
        set_req(2, 0, 1, 32'h3000, rnd_d());
        set_req(3, 0, 1, 32'h4000, rnd_d());
        step();
        chk("t6_resp_rdy", WD'(REQ_RDY), WD'(0));
        MEM_RDY = 0;
        step();
        chk("t3_gid3", WD'(GRANT_ID), WD'(3));
        chk("t3_addr3", WD'(MEM_ADDR), WD'(32'h4000));
        MEM_RDY = 1; MEM_Q = rnd_d();
        step();
        chk("t3_rdy3", WD'(REQ_RDY), WD'(4'b1000));
        clr_req(3); MEM_RDY = 0;
        step(); step();
        chk("t3_gid2", WD'(GRANT_ID), WD'(2));
        chk("t3_addr2", WD'(MEM_ADDR), WD'(32'h3000));
        MEM_RDY = 1; MEM_Q = rnd_d();
        step();
        clr_req(2); MEM_RDY = 0;
        step();

        // Reset during ISSUE, then port 1 is re-granted
        set_req(1, 0, 1, 32'h5000, rnd_d());
        step();
        chk("t5_re", WD'(MEM_RE), WD'(1));
        RST = 1;
        step();
        chk("t5_re_drop", WD'(MEM_RE), WD'(0));
        chk("t5_gid0", WD'(GRANT_ID), WD'(0));
        RST = 0;
        step();
        chk("t5_regrant", WD'(GRANT_ID), WD'(1));
        qv = rnd_d();
        MEM_RDY = 1; MEM_Q = qv;
        step();
        chk("t5_rdy", WD'(REQ_RDY), WD'(4'b0010));
        chk("t5_q", REQ_Q, qv);
        clr_req(1); MEM_RDY = 0;
        step();

        // Zero-wait streaming from all ports
        for (int i = 0; i < N; i++) begin rem[i] = 1000; rand_req(i); end
        mem_mode = 1; MEM_RDY = 1;
        for (int c = 0; c < 30; c++) cyc();
        for (int c = 0; c < 300; c++) begin
            step();
            for (int i = 0; i < N; i++) rdy_cnt[i] += int'(REQ_RDY[i]);
            agent();
        end
        tot = 0;
        for (int i = 0; i < N; i++) begin
            tot += rdy_cnt[i];
            chk("t4_per_port", WD'(rdy_cnt[i]), WD'(25));
        end
        chk("t4_total", WD'(tot), WD'(100));
        for (int i = 0; i < N; i++) rem[i] = 1;
        for (int c = 0; c < 20; c++) cyc();
        chk("t4_drained", WD'(REQ_WE | REQ_RE), WD'(0));

        // Random traffic with random memory latency
        mem_mode = 2; refill = 1;
        for (int c = 0; c < 1500; c++) cyc();
        refill = 0;
        for (int c = 0; c < 300 && (REQ_WE | REQ_RE) != '0; c++) cyc();
        chk("rand_drained", WD'(REQ_WE | REQ_RE), WD'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
